csr_trap_ctrl: RTL and testbench
================================

# csr_trap_ctrl

Trap and CSR-port controller for the RV32 core. It owns the CSR file write port and arbitrates it between pipeline CSR instructions and controller-generated writes. It sequences WFI sleep, interrupt entry to mtvec and mret return to mepc, and drives pipeline stall, flush and PC redirect. It sits between the EX stage, the CSR file and the IF-stage PC mux.

## Interface
- `XLEN`, 32, data/PC width
- `SYNC_STAGES`, 2, irq synchronizer depth (≥2)
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `irq_i`  in  1  external interrupt, level, asynchronous to `clk`
- `meie_i`  in  1  mie[11] from CSR file
- `wfi_i`  in  1  WFI in EX, one-cycle pulse
- `wfi_pc_i`  in  XLEN  PC of that WFI
- `mret_i`  in  1  MRET in EX, one-cycle pulse
- `mtvec_i`, `mepc_i`  in  XLEN  current CSR values
- `csr_wr_req_i`  in  1  pipeline CSR write request
- `csr_wr_addr_i`  in  12  request address
- `csr_wr_data_i`  in  XLEN  request data
- `csr_wr_gnt_o`  out  1  request accepted this cycle
- `csr_we_o`  out  1  CSR file write enable
- `csr_waddr_o`  out  12  CSR file write address
- `csr_wdata_o`  out  XLEN  CSR file write data
- `trap_enter_o`  out  1  pulse; CSR file updates MIE/MPIE and sets mip[11]
- `trap_exit_o`  out  1  pulse; CSR file restores MIE and clears mip[11]
- `redirect_o`  out  1  PC redirect
- `redirect_pc_o`  out  XLEN  redirect target
- `flush_o`  out  1  flush IF/ID
- `stall_o`  out  1  freeze pipeline
- `sleep_cycles_o`  out  32  length of the last/current sleep

## Operation
- FSM states: RUN, SLEEP, ENTER, HANDLER, EXIT. Reset state is RUN.
- Reset values: all outputs 0; pending flag 0; synchronizer 0; counter 0.
- irq path: `SYNC_STAGES`-flop synchronizer, then a rising-edge detect. A rising edge sets `pend` in RUN or HANDLER. `pend` is cleared in ENTER.
- RUN:
  - `wfi_i & meie_i`: the controller writes mepc = `wfi_pc_i`+4 (addr 12'h341) the same cycle, `stall_o`=1, next state SLEEP, `sleep_cycles_o` cleared.
  - `wfi_i & !meie_i`: WFI is a no-op and the state stays RUN.
  - `mret_i` in RUN is ignored.
- SLEEP: `stall_o`=1 and `sleep_cycles_o` increments each cycle, saturating at 32'hFFFFFFFF. If `(pend | irq_sync) & meie_i`, next state is ENTER.
- ENTER (1 cycle): `trap_enter_o`, `redirect_o`, `flush_o`=1, `redirect_pc_o`=`mtvec_i`, `stall_o`=0. Next state HANDLER.
- HANDLER: normal execution; new interrupts only set `pend` (no nesting). `mret_i` moves to EXIT.
- EXIT (1 cycle): `trap_exit_o`, `redirect_o`, `flush_o`=1, `redirect_pc_o`=`mepc_i`. Next state RUN; a `pend` set during the handler persists.
- CSR port arbitration:
  - Controller write has priority over a pipeline request.
  - `csr_wr_gnt_o = csr_wr_req_i & !ctrl_write & state∈{RUN,HANDLER}`.
  - On grant, the request is forwarded combinationally to `csr_we_o/waddr/wdata`.
  - The pipeline holds the request stable until granted.
  - `csr_wr_gnt_o` is 0 in SLEEP, ENTER and EXIT.
- All CSR and redirect outputs are combinational from state and inputs; state, `pend`, sync and counter are registered.

## Timing
- WFI to sleep: `stall_o` is high in the `wfi_i` cycle; SLEEP starts from the next edge.
- Wake latency: irq high before edge k → sync output high after edge k+SYNC_STAGES-1 → ENTER after edge k+SYNC_STAGES → HANDLER one edge later. This is 3 edges for the default depth.
- If `pend` is already set when WFI is taken, SLEEP lasts exactly 1 cycle and `sleep_cycles_o`=1.
- `wfi_i` and `csr_wr_req_i` in the same cycle: the mepc write wins and gnt=0. The request is granted in the next cycle the state is RUN/HANDLER.
- `mret_i` and an irq edge in the same HANDLER cycle: go to EXIT, and `pend` is set.
- `rst` mid-operation returns to RUN immediately (asynchronously) with all outputs 0; no partial CSR write is issued.

## Structure
- `csr_ctrl_pkg`:
  - state enum `trap_state_e`
  - CSR address constants: MSTATUS 12'h300, MIE 12'h304, MTVEC 12'h305, MEPC 12'h341, MIP 12'h344
  - MTVEC_DEFAULT 32'h0001_0000
- Sub-module `irq_sync_edge`: parameterized synchronizer plus rising-edge detector; outputs `irq_sync`, `irq_rise`.

## Test plan
- Reset, then `wfi_i`=1, `wfi_pc_i`=0x100, `meie_i`=1 → same cycle: `csr_we_o`=1, `waddr`=0x341, `wdata`=0x104, `stall_o`=1; state SLEEP.
- In SLEEP, hold irq low for 20 cycles → `sleep_cycles_o`=20, `stall_o` stays 1, no gnt. Then raise irq → after 3 edges: `redirect_o`=1, `redirect_pc_o`=0x00010000, `trap_enter_o`=1 for exactly 1 cycle.
- In HANDLER with `mepc_i`=0x104, pulse `mret_i` → next cycle `trap_exit_o`=1, `redirect_pc_o`=0x104, `flush_o`=1; state returns to RUN.
- Same-cycle `wfi_i` and `csr_wr_req_i` (addr 0x304, data 0x800) → gnt=0 and the mepc write is issued. After wake and ENTER, the request is granted in the first HANDLER cycle.
- WFI with `meie_i`=0 → no write, no stall. Irq edge in RUN followed by WFI with meie=1 → SLEEP for 1 cycle, then ENTER.
- Assert `rst` during SLEEP and during ENTER → all outputs 0 immediately; after release, state RUN and `sleep_cycles_o`=0.

Source files
------------

// File: rtl/csr_ctrl_pkg.sv
// Shared types and constants for the trap/CSR-port controller.
// Holds the FSM state encoding, machine-mode CSR addresses and the saturating counter helper.
package csr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SLEEP,
    ST_ENTER,
    ST_HANDLER,
    ST_EXIT
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] MTVEC_DEFAULT = 32'h0001_0000;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl_irq_sync_edge.sv
// Multi-flop synchronizer for the asynchronous interrupt line plus a rising-edge detector
// on the synchronized level.
module irq_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  output logic irq_sync_o,
  output logic irq_rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], irq_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign irq_sync_o = sync_q[STAGES-1];
  assign irq_rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap controller: sequences WFI sleep, interrupt entry and mret return, and owns the
// CSR file write port, arbitrating controller writes against pipeline CSR requests.
module csr_trap_ctrl
  import csr_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq_i,
  input  logic            meie_i,
  input  logic            wfi_i,
  input  logic [XLEN-1:0] wfi_pc_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            csr_wr_req_i,
  input  logic [11:0]     csr_wr_addr_i,
  input  logic [XLEN-1:0] csr_wr_data_i,
  output logic            csr_wr_gnt_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            trap_enter_o,
  output logic            trap_exit_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic [31:0]     sleep_cycles_o
);

  trap_state_e state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] cnt_q, cnt_d;
  logic        irq_sync, irq_rise;
  logic        ctrl_write;

  irq_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk       (clk),
    .rst       (rst),
    .irq_i     (irq_i),
    .irq_sync_o(irq_sync),
    .irq_rise_o(irq_rise)
  );

  assign ctrl_write = (state_q == ST_RUN) & wfi_i & meie_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (irq_rise) pend_d = 1'b1;
        if (ctrl_write) begin
          state_d = ST_SLEEP;
          cnt_d   = '0;
        end
      end
      ST_SLEEP: begin
        cnt_d = sat_inc(cnt_q);
        if ((pend_q | irq_sync) & meie_i) state_d = ST_ENTER;
      end
      ST_ENTER: begin
        pend_d  = 1'b0;
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (irq_rise) pend_d = 1'b1;
        if (mret_i) state_d = ST_EXIT;
      end
      ST_EXIT:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Outputs are gated by rst so no combinational write escapes while reset is held.
  always_comb begin
    csr_wr_gnt_o  = 1'b0;
    csr_we_o      = 1'b0;
    csr_waddr_o   = '0;
    csr_wdata_o   = '0;
    trap_enter_o  = 1'b0;
    trap_exit_o   = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    flush_o       = 1'b0;
    stall_o       = 1'b0;
    if (!rst) begin
      csr_wr_gnt_o = csr_wr_req_i & ~ctrl_write &
                     ((state_q == ST_RUN) | (state_q == ST_HANDLER));
      if (ctrl_write) begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = wfi_pc_i + XLEN'(4);
        stall_o     = 1'b1;
      end else if (csr_wr_gnt_o) begin
        csr_we_o    = 1'b1;
        csr_waddr_o = csr_wr_addr_i;
        csr_wdata_o = csr_wr_data_i;
      end
      unique case (state_q)
        ST_SLEEP: stall_o = 1'b1;
        ST_ENTER: begin
          trap_enter_o  = 1'b1;
          redirect_o    = 1'b1;
          flush_o       = 1'b1;
          redirect_pc_o = mtvec_i;
        end
        ST_EXIT: begin
          trap_exit_o   = 1'b1;
          redirect_o    = 1'b1;
          flush_o       = 1'b1;
          redirect_pc_o = mepc_i;
        end
        default: ;
      endcase
    end
  end

  assign sleep_cycles_o = cnt_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed self-checking bench for csr_trap_ctrl: expected output snapshots are queued as
// each step is driven and compared against the DUT outputs mid-cycle.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq, meie, wfi, mret, req;
  logic [31:0] wfi_pc, mtvec, mepc, wdata_in;
  logic [11:0] waddr_in;

  logic        gnt, we, t_enter, t_exit, redir, flush, stall;
  logic [11:0] waddr;
  logic [31:0] wdata, rpc, scyc;

  typedef struct packed {
    logic        gnt;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        enter;
    logic        exit_;
    logic        redir;
    logic [31:0] rpc;
    logic        flush;
    logic        stall;
    logic [31:0] scyc;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  e;
  } item_t;

  item_t sb[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  csr_trap_ctrl #(
    .XLEN       (32),
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_i         (irq),
    .meie_i        (meie),
    .wfi_i         (wfi),
    .wfi_pc_i      (wfi_pc),
    .mret_i        (mret),
    .mtvec_i       (mtvec),
    .mepc_i        (mepc),
    .csr_wr_req_i  (req),
    .csr_wr_addr_i (waddr_in),
    .csr_wr_data_i (wdata_in),
    .csr_wr_gnt_o  (gnt),
    .csr_we_o      (we),
    .csr_waddr_o   (waddr),
    .csr_wdata_o   (wdata),
    .trap_enter_o  (t_enter),
    .trap_exit_o   (t_exit),
    .redirect_o    (redir),
    .redirect_pc_o (rpc),
    .flush_o       (flush),
    .stall_o       (stall),
    .sleep_cycles_o(scyc)
  );

  function automatic obs_t quiet(input logic [31:0] n);
    obs_t e;
    e = '0;
    e.scyc = n;
    return e;
  endfunction

  function automatic obs_t slp(input logic [31:0] n);
    obs_t e;
    e = quiet(n);
    e.stall = 1'b1;
    return e;
  endfunction

  function automatic obs_t mepc_wr(input logic [31:0] d, input logic [31:0] n);
    obs_t e;
    e = slp(n);
    e.we    = 1'b1;
    e.waddr = 12'h341;
    e.wdata = d;
    return e;
  endfunction

  function automatic obs_t ent(input logic [31:0] n);
    obs_t e;
    e = quiet(n);
    e.enter = 1'b1;
    e.redir = 1'b1;
    e.flush = 1'b1;
    e.rpc   = 32'h0001_0000;
    return e;
  endfunction

  function automatic obs_t ext(input logic [31:0] pc, input logic [31:0] n);
    obs_t e;
    e = quiet(n);
    e.exit_ = 1'b1;
    e.redir = 1'b1;
    e.flush = 1'b1;
    e.rpc   = pc;
    return e;
  endfunction

  function automatic obs_t grant(input logic [11:0] a, input logic [31:0] d, input logic [31:0] n);
    obs_t e;
    e = quiet(n);
    e.gnt   = 1'b1;
    e.we    = 1'b1;
    e.waddr = a;
    e.wdata = d;
    return e;
  endfunction

  function automatic obs_t snap();
    obs_t o;
    o.gnt = gnt;   o.we = we;        o.waddr = waddr; o.wdata = wdata;
    o.enter = t_enter; o.exit_ = t_exit; o.redir = redir; o.rpc = rpc;
    o.flush = flush; o.stall = stall; o.scyc = scyc;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t e);
    item_t it;
    obs_t  o;
    sb.push_back('{tag: tag, e: e});
    it = sb.pop_front();
    o  = snap();
    n_total++;
    assert (o === it.e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", it.tag, o, it.e);
  endtask

  task automatic cyc(input string tag, input obs_t e);
    @(negedge clk);
    chk(tag, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; irq = 1'b0; meie = 1'b1; wfi = 1'b1; wfi_pc = 32'h100; mret = 1'b0;
    mtvec = 32'h0001_0000; mepc = 32'h104; req = 1'b0; waddr_in = '0; wdata_in = '0;
    @(posedge clk); #1;
    cyc("reset_outputs", quiet(0));
    rst = 1'b0; wfi = 1'b0;
    cyc("run_idle", quiet(0));

    wfi = 1'b1; req = 1'b1; waddr_in = 12'h304; wdata_in = 32'h800;
    cyc("wfi_mepc_wins", mepc_wr(32'h104, 0));
    wfi = 1'b0;
    for (int i = 0; i < 20; i++) cyc("sleep_count", slp(32'(i)));
    irq = 1'b1;
    cyc("sleep_20", slp(20));
    cyc("sleep_sync1", slp(21));
    cyc("sleep_sync2", slp(22));
    cyc("enter_trap", ent(23));
    cyc("handler_grant", grant(12'h304, 32'h800, 23));
    req = 1'b0;
    cyc("handler_idle", quiet(23));
    mret = 1'b1;
    cyc("handler_mret", quiet(23));
    mret = 1'b0; irq = 1'b0;
    cyc("exit_trap", ext(32'h104, 23));
    cyc("run_after_exit", quiet(23));

    meie = 1'b0; wfi = 1'b1; wfi_pc = 32'h200;
    cyc("wfi_meie0", quiet(23));
    wfi = 1'b0; meie = 1'b1;
    cyc("wfi_noop_run", quiet(23));
    mret = 1'b1;
    cyc("mret_in_run", quiet(23));
    mret = 1'b0;
    cyc("mret_ignored", quiet(23));
    req = 1'b1; waddr_in = 12'h300; wdata_in = 32'h88;
    cyc("run_grant", grant(12'h300, 32'h88, 23));
    req = 1'b0;

    irq = 1'b1;
    cyc("irq_pulse_a", quiet(23));
    irq = 1'b0;
    cyc("irq_pulse_b", quiet(23));
    cyc("irq_pulse_c", quiet(23));
    wfi = 1'b1; wfi_pc = 32'h300;
    cyc("wfi_pend", mepc_wr(32'h304, 23));
    wfi = 1'b0;
    cyc("sleep_one", slp(0));
    cyc("enter_pend", ent(1));

    mepc = 32'h304; irq = 1'b1;
    cyc("handler_a", quiet(1));
    cyc("handler_b", quiet(1));
    mret = 1'b1;
    cyc("mret_irq_same", quiet(1));
    mret = 1'b0; irq = 1'b0;
    cyc("exit_pend", ext(32'h304, 1));
    wfi = 1'b1; wfi_pc = 32'h400;
    cyc("wfi_pend_kept", mepc_wr(32'h404, 1));
    wfi = 1'b0;
    cyc("sleep_pend_kept", slp(0));

    #2 chk("enter_before_rst", ent(1));
    rst = 1'b1;
    #1 chk("rst_in_enter", quiet(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("run_after_rst1", quiet(0));

    wfi = 1'b1; wfi_pc = 32'h500;
    cyc("wfi_again", mepc_wr(32'h504, 0));
    wfi = 1'b0;
    cyc("sleep_r0", slp(0));
    cyc("sleep_r1", slp(1));
    #2 chk("sleep_before_rst", slp(2));
    rst = 1'b1;
    #1 chk("rst_in_sleep", quiet(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("run_after_rst2", quiet(0));
    req = 1'b1; waddr_in = 12'h304; wdata_in = 32'h800;
    cyc("grant_after_rst", grant(12'h304, 32'h800, 0));
    req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
